servo_motion_sequencer: RTL
===========================

Name: servo_motion_sequencer

Overview:
- Rate-limited motion controller for the manipulator's joint servos. It sits between the command source (host/UART decoder) and the per-joint PWM generators.
- Accepts target angles per joint over a valid/ready handshake. Once per servo frame, it steps each joint's commanded angle toward its target by at most STEP_DEG.
- Drives the per-joint angle buses into the PWM instances, so joints never jump full-scale within one 20 ms frame.

Parameters:
- NUM_JOINTS, 4, number of servo joints sequenced
- JOINT_W, 2, width of joint index (ceil log2 NUM_JOINTS, min 1)
- FRAME_CYCLES, 1000000, clk cycles per servo frame (20 ms at 50 MHz)
- STEP_DEG, 2, max angle change per joint per frame, integer degrees, >=1
- ANGLE_MAX, 180, upper clamp for targets, integer degrees
- HOME_DEG, 90, reset value of all targets and angles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept command this cycle
- cmd_joint  in  JOINT_W  joint index of command
- cmd_angle  in  16  target angle, unsigned integer degrees
- hold  in  1  freeze motion (no steps taken while high)
- angle_flat  out  16*NUM_JOINTS  current joint angles, joint j at [16j+15:16j], unsigned integer degrees
- frame_tick  out  1  one-cycle pulse at each frame boundary
- busy  out  1  high while any joint angle != its target
- done  out  1  one-cycle pulse when motion completes
- cmd_err  out  1  one-cycle pulse on accepted command with illegal joint index

Behaviour:
- Reset (reset=0, async):
  - All targets and angles = HOME_DEG; frame counter = 0; FSM = IDLE.
  - cmd_ready=1, frame_tick=0, busy=0, done=0, cmd_err=0.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps.
  - frame_tick is registered: high in the cycle after counter == FRAME_CYCLES-1.
  - The counter free-runs regardless of hold.
- Handshake:
  - Transfer occurs when cmd_valid && cmd_ready at a rising edge.
  - cmd_ready = 1 in IDLE, 0 in SWEEP.
  - A transfer writes target[cmd_joint] = min(cmd_angle, ANGLE_MAX).
  - If cmd_joint >= NUM_JOINTS: the command is accepted but dropped, and cmd_err pulses the next cycle.
  - Back-to-back commands in IDLE are accepted one per cycle; the last write to a joint wins.
- FSM:
  - IDLE: if frame_tick && !hold, go to SWEEP with index j=0. A command accepted in the frame_tick cycle is written before the sweep reads it.
  - SWEEP: one joint per cycle, j=0..NUM_JOINTS-1.
    - If angle[j] < target[j]: angle[j] += min(STEP_DEG, target-angle).
    - If angle[j] > target[j]: angle[j] -= min(STEP_DEG, angle-target).
    - Otherwise angle[j] is unchanged.
    - After j=NUM_JOINTS-1, return to IDLE.
  - Latency: joint j's angle changes at edge tick+1+j; the sweep lasts NUM_JOINTS cycles.
  - Requirement: FRAME_CYCLES > NUM_JOINTS+1.
- Arithmetic:
  - Unsigned 16-bit throughout; no overshoot, no wrap.
  - Angles stay within [0, ANGLE_MAX] once targets are clamped.
  - HOME_DEG must be <= ANGLE_MAX.
- busy: registered, = OR over j of (angle[j] != target[j]); updates one cycle after any angle or target change.
- done: pulses one cycle when busy falls 1->0. No pulse if a command sets a target equal to the current angle, since busy never rises.
- hold:
  - Sampled only at frame_tick in IDLE.
  - A sweep already in progress completes even if hold rises mid-sweep.
  - Commands are still accepted while hold is high.
- Reset mid-sweep: everything returns to reset values immediately; the partial sweep is discarded.

Test Plan:
(Parameters for T1–T5: FRAME_CYCLES=100, NUM_JOINTS=4, STEP_DEG=2.)
- T1 reset: release reset -> all angle_flat fields = 90, busy=0, cmd_ready=1, first frame_tick at cycle 100 after release.
- T2 ramp: cmd joint1=95 -> busy=1; joint1 steps 92, 94, 95 on three successive frames, each at tick+2; done pulses once after 95; other joints stay 90.
- T3 clamp/error: cmd joint0=300 -> target 180, joint0 ramps +2/frame to 180. cmd_joint=5 with NUM_JOINTS=4 (JOINT_W=3) -> cmd_err pulse, no target changes.
- T4 collision: assert cmd_valid (joint2=80) in the frame_tick cycle -> accepted; joint2 = 88 at tick+3; cmd_ready low for exactly 4 cycles after tick.
- T5 hold: hold=1 across 3 frame_ticks with pending target -> angles unchanged, busy stays 1; hold=0 -> stepping resumes next frame.
- T6 async reset mid-sweep: assert reset at tick+2 -> all angles 90 immediately, cmd_ready=1 after release, no done pulse.

Source files
------------

// File: rtl/servo_motion_sequencer.sv
// Rate-limited servo motion sequencer: accepts per-joint targets and, once per
// frame, sweeps every joint toward its target by at most STEP_DEG degrees.
module servo_motion_sequencer #(
    parameter int NUM_JOINTS   = 4,
    parameter int JOINT_W      = 2,
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP_DEG     = 2,
    parameter int ANGLE_MAX    = 180,
    parameter int HOME_DEG     = 90
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [JOINT_W-1:0]           cmd_joint,
    input  logic [15:0]                  cmd_angle,
    input  logic                         hold,
    output logic [16*NUM_JOINTS-1:0]     angle_flat,
    output logic                         frame_tick,
    output logic                         busy,
    output logic                         done,
    output logic                         cmd_err,
    output logic [JOINT_W:0]             dbg_state
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [15:0]        STEP     = 16'(STEP_DEG);
    localparam logic [15:0]        AMAX     = 16'(ANGLE_MAX);
    localparam logic [15:0]        HOME     = 16'(HOME_DEG);
    localparam logic [JOINT_W:0]   NJ       = (JOINT_W + 1)'(NUM_JOINTS);
    localparam logic [JOINT_W-1:0] LAST_J   = JOINT_W'(NUM_JOINTS - 1);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    state_e                         state_q, state_d;
    logic [JOINT_W-1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]               cnt_q;
    logic                           tick_q, busy_q, done_q, err_q;
    logic [NUM_JOINTS-1:0][15:0]    tgt_q, tgt_d, ang_q, ang_d;
    logic                           accept, bad_joint, any_diff;
    logic [15:0]                    cmd_clamped;

    // Free-running frame counter; the tick is registered off the terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            tick_q <= (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_q && !hold) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (idx_q == LAST_J) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + JOINT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        dbg_state = {state_q == ST_SWEEP, idx_q};
    end

    // Commands only land in IDLE, so a target never changes under the joint being swept.
    always_comb begin
        accept      = cmd_valid && cmd_ready;
        bad_joint   = ({1'b0, cmd_joint} >= NJ);
        cmd_clamped = (cmd_angle > AMAX) ? AMAX : cmd_angle;
        tgt_d       = tgt_q;
        ang_d       = ang_q;
        any_diff    = 1'b0;
        for (int j = 0; j < NUM_JOINTS; j++) begin
            any_diff = any_diff | (ang_q[j] != tgt_q[j]);
            if (accept && !bad_joint && (cmd_joint == JOINT_W'(j))) begin
                tgt_d[j] = cmd_clamped;
            end
            if ((state_q == ST_SWEEP) && (idx_q == JOINT_W'(j))) begin
                if (ang_q[j] < tgt_q[j]) begin
                    ang_d[j] = ((tgt_q[j] - ang_q[j]) > STEP) ? ang_q[j] + STEP : tgt_q[j];
                end else if (ang_q[j] > tgt_q[j]) begin
                    ang_d[j] = ((ang_q[j] - tgt_q[j]) > STEP) ? ang_q[j] - STEP : tgt_q[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q  <= {NUM_JOINTS{HOME}};
            ang_q  <= {NUM_JOINTS{HOME}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            ang_q  <= ang_d;
            busy_q <= any_diff;
            done_q <= busy_q && !any_diff;
            err_q  <= accept && bad_joint;
        end
    end

    assign angle_flat = ang_q;
    assign frame_tick = tick_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_err    = err_q;

endmodule
